// File: rtl/opendap_swd_host_pkg.sv
// Shared definitions for the SWD host: FSM state encoding, ACK codes,
// line-reset lengths, data-phase length and the request-header builder.
package opendap_swd_host_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LRST,
    ST_HDR,
    ST_TRN1,
    ST_ACK,
    ST_TRN2,
    ST_WDATA,
    ST_RDATA,
    ST_TRN3,
    ST_PAD
  } state_t;

  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;

  localparam int unsigned LRST_HIGH_CYCLES = 56;
  localparam int unsigned LRST_LOW_CYCLES  = 8;
  localparam int unsigned DATA_CYCLES      = 33;  // 32 data bits + parity

  // Request header, bit 0 is sent first:
  // start, APnDP, RnW, A2, A3, parity, stop, park
  function automatic logic [7:0] swd_header(input logic       ap_ndp,
                                            input logic       r_nw,
                                            input logic [1:0] addr);
    logic par;
    par = ap_ndp ^ r_nw ^ addr[0] ^ addr[1];
    return {1'b1, 1'b0, par, addr[1], addr[0], r_nw, ap_ndp, 1'b1};
  endfunction

endpackage

// File: rtl/opendap_swd_host_clkgen.sv
// SWCLK divider. swclk_o rests low while en_i is low; while enabled it
// toggles every div_i+1 clk cycles.
//   clk, rst_n : system clock, async active-low reset
//   en_i       : run the divider
//   div_i      : half-period minus one, in clk cycles
//   swclk_o    : SWCLK pin
//   rise_o     : high in the clk cycle whose closing edge takes swclk_o 0->1
//   fall_o     : high in the clk cycle whose closing edge takes swclk_o 1->0
module opendap_swd_clkgen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [7:0] div_i,
  output logic       swclk_o,
  output logic       rise_o,
  output logic       fall_o
);

  logic [7:0] cnt_q;
  logic       swclk_q;
  logic       tick;

  assign tick    = en_i && (cnt_q == div_i);
  assign rise_o  = tick && !swclk_q;
  assign fall_o  = tick && swclk_q;
  assign swclk_o = swclk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      swclk_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q   <= '0;
      swclk_q <= 1'b0;
    end else if (tick) begin
      cnt_q   <= '0;
      swclk_q <= ~swclk_q;
    end else begin
      cnt_q   <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/opendap_swd_host.sv
// SWD host: runs one SWD transfer (or a line reset) per accepted command.
//   clk, rst_n              : system clock, async active-low reset
//   clk_div                 : SWCLK half-period = clk_div+1 clk cycles
//   cmd_valid / cmd_ready   : command handshake
//   cmd_linereset           : issue a line reset instead of a transfer
//   cmd_ap_ndp, cmd_r_nw,
//   cmd_addr, cmd_wdata     : header fields and write data
//   rsp_valid               : one-clk completion pulse
//   rsp_ack, rsp_rdata,
//   rsp_perr                : ACK (bit 0 first received), read data, parity error
//   swclk_o, swdo, swdo_en  : SWD pins (drive side)
//   swdi                    : SWDIO input, already synchronised
module opendap_swd_host
  import opendap_swd_host_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 2  // must be >= 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  clk_div,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_linereset,
  input  logic        cmd_ap_ndp,
  input  logic        cmd_r_nw,
  input  logic [1:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [2:0]  rsp_ack,
  output logic [31:0] rsp_rdata,
  output logic        rsp_perr,
  output logic        swclk_o,
  output logic        swdo,
  output logic        swdo_en,
  input  logic        swdi
);

  state_t      state_q, state_d;
  logic [5:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  div_q, hdr_q, hdr_cur;
  logic        r_nw_q;
  logic [31:0] wdata_q;
  logic [2:0]  ack_sh_q;
  logic [31:0] rd_sh_q;
  logic        rpar_q;
  logic        swdo_q, swdo_en_q;
  logic        rsp_valid_q, rsp_perr_q;
  logic [2:0]  rsp_ack_q;
  logic [31:0] rsp_rdata_q;
  logic        busy, rise, fall, accept, done;
  logic        drv_val, drv_en;

  assign busy      = (state_q != ST_IDLE);
  assign cmd_ready = (state_q == ST_IDLE);
  assign accept    = cmd_valid && (state_q == ST_IDLE);
  assign swdo      = swdo_q;
  assign swdo_en   = swdo_en_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_ack   = rsp_ack_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_perr  = rsp_perr_q;

  opendap_swd_clkgen u_clkgen (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (busy),
    .div_i   (div_q),
    .swclk_o (swclk_o),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  function automatic logic [5:0] last_bit(input state_t s);
    case (s)
      ST_LRST:            return 6'(LRST_HIGH_CYCLES + LRST_LOW_CYCLES - 1);
      ST_HDR:             return 6'd7;
      ST_ACK:             return 6'd2;
      ST_WDATA, ST_RDATA: return 6'(DATA_CYCLES - 1);
      ST_PAD:             return 6'(IDLE_CYCLES - 1);
      default:            return 6'd0;
    endcase
  endfunction

  // Each SWCLK cycle runs fall-to-fall, so states advance on the fall strobe.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    done     = 1'b0;
    if (accept) begin
      state_d  = cmd_linereset ? ST_LRST : ST_HDR;
      bitcnt_d = '0;
    end else if (fall) begin
      if (bitcnt_q != last_bit(state_q)) begin
        bitcnt_d = bitcnt_q + 6'd1;
      end else begin
        bitcnt_d = '0;
        case (state_q)
          ST_HDR:   state_d = ST_TRN1;
          ST_TRN1:  state_d = ST_ACK;
          ST_ACK:   state_d = (ack_sh_q != ACK_OK) ? ST_TRN3 :
                              (r_nw_q ? ST_RDATA : ST_TRN2);
          ST_TRN2:  state_d = ST_WDATA;
          ST_WDATA: state_d = ST_PAD;
          ST_RDATA: state_d = ST_TRN3;
          ST_TRN3:  state_d = ST_PAD;
          ST_PAD, ST_LRST: begin
            state_d = ST_IDLE;
            done    = 1'b1;
          end
          default:  state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Pin value for the SWCLK cycle about to start. The first header bit is
  // loaded on acceptance (SWCLK is resting low), so the header is built
  // from the live command fields in that cycle.
  always_comb begin
    hdr_cur = accept ? swd_header(cmd_ap_ndp, cmd_r_nw, cmd_addr) : hdr_q;
    drv_val = 1'b0;
    drv_en  = 1'b0;
    case (state_d)
      ST_LRST: begin
        drv_en  = 1'b1;
        drv_val = (bitcnt_d < 6'(LRST_HIGH_CYCLES));
      end
      ST_HDR: begin
        drv_en  = 1'b1;
        drv_val = hdr_cur[bitcnt_d[2:0]];
      end
      ST_WDATA: begin
        drv_en  = 1'b1;
        drv_val = bitcnt_d[5] ? ^wdata_q : wdata_q[bitcnt_d[4:0]];
      end
      ST_PAD:  drv_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= '0;
      div_q       <= '0;
      hdr_q       <= '0;
      r_nw_q      <= 1'b0;
      wdata_q     <= '0;
      ack_sh_q    <= '0;
      rd_sh_q     <= '0;
      rpar_q      <= 1'b0;
      swdo_q      <= 1'b0;
      swdo_en_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_ack_q   <= '0;
      rsp_rdata_q <= '0;
      rsp_perr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      if (accept) begin
        div_q   <= clk_div;
        hdr_q   <= swd_header(cmd_ap_ndp, cmd_r_nw, cmd_addr);
        r_nw_q  <= cmd_r_nw;
        wdata_q <= cmd_wdata;
      end
      if (accept || fall) begin
        swdo_q    <= drv_val;
        swdo_en_q <= drv_en;
      end
      if (rise) begin
        if (state_q == ST_ACK) ack_sh_q <= {swdi, ack_sh_q[2:1]};
        if (state_q == ST_RDATA) begin
          if (bitcnt_q[5]) rpar_q  <= swdi;
          else             rd_sh_q <= {swdi, rd_sh_q[31:1]};
        end
      end
      rsp_valid_q <= done;
      if (done) begin
        if (state_q == ST_LRST) begin
          rsp_ack_q   <= '0;
          rsp_rdata_q <= '0;
          rsp_perr_q  <= 1'b0;
        end else begin
          rsp_ack_q <= ack_sh_q;
          if (ack_sh_q == ACK_OK && r_nw_q) begin
            rsp_rdata_q <= rd_sh_q;
            rsp_perr_q  <= rpar_q ^ (^rd_sh_q);
          end else begin
            rsp_rdata_q <= '0;
            rsp_perr_q  <= 1'b0;
          end
        end
      end
    end
  end

endmodule
